// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump reader.
// Widths match the CPU register file (16 x 32-bit).
package regfile_dump_pkg;

  localparam int default_data_width = 32;
  localparam int default_addr_width = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EMIT0 = 3'd2,
    EMIT1 = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pair-index width; kept at least 1 bit so a two-register file still has a counter.
  function automatic int pair_width(input int aw);
    return (aw > 1) ? aw - 1 : 1;
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Freezes register-file writes and streams every (address, value) pair,
// read two at a time, to the debug host over valid/ready.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int data_width = default_data_width,
  parameter int addr_width = default_addr_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  freeze,
  output logic [addr_width-1:0] rd0_addr,
  output logic [addr_width-1:0] rd1_addr,
  input  logic [data_width-1:0] rd0_data,
  input  logic [data_width-1:0] rd1_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [addr_width-1:0] out_addr,
  output logic [data_width-1:0] out_data
);

  localparam int kw = pair_width(addr_width);
  localparam logic [kw-1:0] k_last = kw'((2 ** (addr_width - 1)) - 1);

  state_t                state_r;
  state_t                state_s;
  logic [kw-1:0]         k_r;
  logic [kw-1:0]         k_s;
  logic [data_width-1:0] buf0_r;
  logic [data_width-1:0] buf1_r;
  logic [addr_width-1:0] addr0_s;
  logic [addr_width-1:0] addr1_s;

  assign addr0_s = addr_width'({k_r, 1'b0});
  assign addr1_s = addr_width'({k_r, 1'b1});

  // State, pair index and the two-word snapshot buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= '0;
      buf0_r  <= '0;
      buf1_r  <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      // Captured once per pair, so a stalled host never causes a re-read.
      if (state_r == READ) begin
        buf0_r <= rd0_data;
        buf1_r <= rd1_data;
      end else begin
        buf0_r <= buf0_r;
        buf1_r <= buf1_r;
      end
    end
  end

  // Next-state and pair-index sequencing.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = READ;
          k_s     = '0;
        end else begin
          state_s = IDLE;
        end
      end
      READ: state_s = EMIT0;
      EMIT0: begin
        if (out_ready) begin
          state_s = EMIT1;
        end else begin
          state_s = EMIT0;
        end
      end
      EMIT1: begin
        if (!out_ready) begin
          state_s = EMIT1;
        end else if (k_r == k_last) begin
          state_s = DONE;
        end else begin
          state_s = READ;
          k_s     = k_r + kw'(1'b1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    freeze    = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    rd0_addr  = addr0_s;
    rd1_addr  = addr1_s;
    case (state_r)
      IDLE: busy = 1'b0;
      READ: begin
        busy   = 1'b1;
        freeze = 1'b1;
      end
      EMIT0: begin
        busy      = 1'b1;
        freeze    = 1'b1;
        out_valid = 1'b1;
        out_addr  = addr0_s;
        out_data  = buf0_r;
      end
      EMIT1: begin
        busy      = 1'b1;
        freeze    = 1'b1;
        out_valid = 1'b1;
        out_addr  = addr1_s;
        out_data  = buf1_r;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a register-file model with a gated write port, and
// an expected stream equal to the register contents at the start pulse.
module tb_regfile_dump;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, freeze, out_valid, out_ready;
  logic [AW-1:0] rd0_addr, rd1_addr, out_addr;
  logic [DW-1:0] rd0_data, rd1_data, out_data;
  logic [DW-1:0] regs [NR];
  logic          wena;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  logic          m_start, m_busy, m_done, m_freeze, m_valid, m_ready;
  logic [0:0]    m_rd0_addr, m_rd1_addr, m_out_addr;
  logic [DW-1:0] m_rd0_data, m_rd1_data, m_out_data;
  logic [DW-1:0] m_regs [2];
  logic          m_wena;
  logic [0:0]    m_waddr;
  logic [DW-1:0] m_wdata;

  regfile_dump #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .freeze(freeze),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(rd0_data), .rd1_data(rd1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  regfile_dump #(.data_width(DW), .addr_width(1)) dut_min (
    .clk(clk), .rst(rst), .start(m_start), .busy(m_busy), .done(m_done), .freeze(m_freeze),
    .rd0_addr(m_rd0_addr), .rd1_addr(m_rd1_addr), .rd0_data(m_rd0_data), .rd1_data(m_rd1_data),
    .out_valid(m_valid), .out_ready(m_ready), .out_addr(m_out_addr), .out_data(m_out_data)
  );

  // Register files: pipeline writes pass only while not frozen.
  always @(posedge clk) begin
    if (wena && !freeze) regs[waddr] <= wdata;
    if (m_wena && !m_freeze) m_regs[m_waddr] <= m_wdata;
  end
  assign rd0_data   = regs[rd0_addr];
  assign rd1_data   = regs[rd1_addr];
  assign m_rd0_data = m_regs[m_rd0_addr];
  assign m_rd1_data = m_regs[m_rd1_addr];

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_data [NR];
  logic [AW-1:0] got_addr [$];
  logic [DW-1:0] got_data [$];
  logic          fz [256];
  int tick_n, done_cnt, done_tick, first_valid_tick, last_xfer_tick, hold_viol;
  logic          prev_stall;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic          s_valid, s_done, s_busy, s_freeze;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    tick_n = 0; done_cnt = 0; done_tick = -1; first_valid_tick = -1;
    last_xfer_tick = -1; hold_viol = 0; prev_stall = 1'b0;
  endtask

  // One clock: apply inputs, sample at negedge, record transfers/done/freeze.
  task automatic tick(input logic rdy, input logic st);
    out_ready = rdy;
    start     = st;
    @(negedge clk);
    s_valid = out_valid; s_done = done; s_busy = busy; s_freeze = freeze;
    s_addr  = out_addr;  s_data = out_data;
    if (tick_n < 256) fz[tick_n] = freeze;
    if (prev_stall && !(out_valid && out_addr == p_addr && out_data == p_data)) hold_viol++;
    prev_stall = out_valid && !out_ready;
    p_addr = out_addr;
    p_data = out_data;
    if (out_valid && first_valid_tick < 0) first_valid_tick = tick_n;
    if (out_valid && out_ready) begin
      got_addr.push_back(out_addr);
      got_data.push_back(out_data);
      last_xfer_tick = tick_n;
    end
    if (done) begin
      done_cnt++;
      done_tick = tick_n;
    end
    @(posedge clk);
    #1;
    tick_n++;
  endtask

  task automatic preload(input bit fixed);
    for (int i = 0; i < NR; i++) begin
      wena  = 1'b1;
      waddr = AW'(i);
      wdata = fixed ? (32'hA000_0000 + DW'(i)) : DW'($urandom);
      exp_data[i] = wdata;
      @(posedge clk);
      #1;
    end
    wena = 1'b0;
  endtask

  // Start a dump and clock until done is seen or the budget runs out.
  task automatic run_dump(input bit bp, input int write_tick, input int restart_tick, input int max_ticks);
    logic rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    clear_mon();
    tick(1'b1, 1'b1);
    while (done_cnt == 0 && tick_n < max_ticks) begin
      if (tick_n == write_tick) begin
        wena  = 1'b1;
        waddr = AW'(3);
        wdata = 32'h0000_DEAD;
      end
      rdy = bp ? pat[tick_n % 4] : 1'b1;
      tick(rdy, (tick_n == restart_tick) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    vectors++;
    if ({s_busy, s_done, s_freeze, s_valid} !== 4'b0000 || s_addr !== '0 || s_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy/done/freeze/valid=%b addr=%0h data=%0h, required all 0",
               {s_busy, s_done, s_freeze, s_valid}, s_addr, s_data);
    end
    vectors++;
    if (rd0_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_rd0_addr: got %0h required 0", rd0_addr);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_full_dump();
    preload(1'b1);
    run_dump(1'b0, -1, -1, 100);
    vectors++;
    if (got_addr.size() !== NR) begin
      miscompares++;
      $display("FAIL full_count: got %0d words required %0d", got_addr.size(), NR);
    end
    for (int i = 0; i < NR && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL full_word[%0d]: got addr %0h data %0h required addr %0h data %0h",
                 i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (first_valid_tick !== 2) begin
      miscompares++;
      $display("FAIL full_first_valid: got cycle %0d required 2", first_valid_tick);
    end
    vectors++;
    if (done_tick !== 25 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL full_done: got cycle %0d count %0d required cycle 25 count 1", done_tick, done_cnt);
    end
    vectors++;
    if (fz[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL full_freeze_rise: got %b required 1 in READ cycle", fz[1]);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (s_busy !== 1'b0 || s_freeze !== 1'b0) begin
      miscompares++;
      $display("FAIL full_idle_after: busy=%b freeze=%b required 0 0", s_busy, s_freeze);
    end
  endtask

  task automatic test_backpressure();
    int lows;
    preload(1'b0);
    run_dump(1'b1, -1, -1, 200);
    vectors++;
    if (got_addr.size() !== NR || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words %0d done required %0d words 1 done", got_addr.size(), done_cnt, NR);
    end
    for (int i = 0; i < NR && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL bp_word[%0d]: got addr %0h data %0h required addr %0h data %0h",
                 i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (hold_viol !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable stalled cycles required 0", hold_viol);
    end
    lows = 0;
    for (int t = 1; t <= last_xfer_tick && t < 256; t++) if (fz[t] !== 1'b1) lows++;
    vectors++;
    if (lows !== 0 || last_xfer_tick < 1) begin
      miscompares++;
      $display("FAIL bp_freeze: got %0d low cycles before last transfer (cycle %0d) required 0", lows, last_xfer_tick);
    end
    vectors++;
    if (done_tick < 0 || done_tick >= 256 || fz[done_tick] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_freeze_done: freeze not low in done cycle %0d", done_tick);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_snapshot();
    logic [DW-1:0] pre3;
    preload(1'b0);
    pre3 = exp_data[3];
    run_dump(1'b0, 3, -1, 100);
    wena = 1'b0;
    vectors++;
    if (got_data.size() < 4 || got_data[3] !== pre3) begin
      miscompares++;
      $display("FAIL snap_r3: got %0h required pre-dump %0h", (got_data.size() >= 4) ? got_data[3] : '0, pre3);
    end
    vectors++;
    if (regs[3] !== 32'h0000_DEAD) begin
      miscompares++;
      $display("FAIL snap_write_after: got R3=%0h required 0000dead", regs[3]);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_ignored_start();
    preload(1'b0);
    run_dump(1'b0, -1, 5, 100);
    for (int i = 0; i < 30; i++) tick(1'b1, (i == 0) ? 1'b0 : 1'b0);
    vectors++;
    if (got_addr.size() !== NR || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL ign_count: got %0d words %0d done required %0d words 1 done", got_addr.size(), done_cnt, NR);
    end
    for (int i = 0; i < NR && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL ign_word[%0d]: got addr %0h data %0h required addr %0h data %0h",
                 i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_idle: busy=%b required 0", s_busy);
    end
  endtask

  task automatic test_reset_mid();
    preload(1'b0);
    clear_mon();
    tick(1'b1, 1'b1);
    while (tick_n < 9) tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    vectors++;
    if (s_valid !== 1'b1 || s_addr !== 4'd5) begin
      miscompares++;
      $display("FAIL rstmid_pos: got valid=%b addr=%0h required 1 5 (EMIT1 of pair 2)", s_valid, s_addr);
    end
    rst = 1'b0;
    tick(1'b1, 1'b0);
    vectors++;
    if ({s_busy, s_done, s_freeze, s_valid} !== 4'b0000 || s_addr !== '0 || s_data !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: busy/done/freeze/valid=%b addr=%0h data=%0h required all 0",
               {s_busy, s_done, s_freeze, s_valid}, s_addr, s_data);
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++;
      $display("FAIL rstmid_no_done: got %0d done pulses required 0", done_cnt);
    end
    run_dump(1'b0, -1, -1, 100);
    vectors++;
    if (got_addr.size() !== NR || got_addr[0] !== 4'd0 || got_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL rstmid_restart: got %0d words first addr %0h required %0d words first addr 0",
               got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : '0, NR);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_min_size();
    logic [DW-1:0] m_exp [2];
    logic [0:0]    ma [$];
    logic [DW-1:0] md [$];
    int m_done_cnt, m_last_xfer, m_done_at;
    for (int i = 0; i < 2; i++) begin
      m_wena = 1'b1; m_waddr = 1'(i); m_wdata = DW'($urandom);
      m_exp[i] = m_wdata;
      @(posedge clk); #1;
    end
    m_wena = 1'b0;
    m_done_cnt = 0; m_last_xfer = -1; m_done_at = -1;
    for (int t = 0; t < 60; t++) begin
      m_start = (t == 0) ? 1'b1 : 1'b0;
      m_ready = (t > 30) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_valid && m_ready) begin
        ma.push_back(m_out_addr); md.push_back(m_out_data); m_last_xfer = t;
      end
      if (m_done) begin m_done_cnt++; m_done_at = t; end
      @(posedge clk); #1;
    end
    m_start = 1'b0;
    vectors++;
    if (ma.size() !== 2 || m_done_cnt !== 1 || m_done_at <= m_last_xfer) begin
      miscompares++;
      $display("FAIL min_count: got %0d words %0d done (done cycle %0d, last xfer %0d) required 2 words 1 done after",
               ma.size(), m_done_cnt, m_done_at, m_last_xfer);
    end
    for (int i = 0; i < 2 && i < ma.size(); i++) begin
      vectors++;
      if (ma[i] !== 1'(i) || md[i] !== m_exp[i]) begin
        miscompares++;
        $display("FAIL min_word[%0d]: got addr %0h data %0h required addr %0h data %0h", i, ma[i], md[i], i, m_exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    wena = 1'b0; waddr = '0; wdata = '0;
    m_start = 1'b0; m_ready = 1'b0; m_wena = 1'b0; m_waddr = '0; m_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_snapshot();
    test_ignored_start();
    test_reset_mid();
    test_min_size();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
